// File: rtl/alu_sequencer_pkg.sv
// Package alu_pkg: constants and helpers shared by the ALU sequencer, its
// interface and the combinational core.
//   - WIDTH/HALF/CNT_W : full-word width, half-word width, shift-count width
//   - OP_*             : 5-bit opcodes (19..31 reserved)
//   - SR_*             : bit indices into the {sign, zero, carry} status word
package alu_pkg;

    localparam int WIDTH = 20;
    localparam int HALF  = 10;
    localparam int CNT_W = 5;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_NOT   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SHR   = 5'd5;
    localparam logic [4:0] OP_SHL   = 5'd6;
    localparam logic [4:0] OP_ROR   = 5'd7;
    localparam logic [4:0] OP_ROL   = 5'd8;
    localparam logic [4:0] OP_SWAP  = 5'd9;
    localparam logic [4:0] OP_INC   = 5'd10;
    localparam logic [4:0] OP_DEC   = 5'd11;
    localparam logic [4:0] OP_ADD   = 5'd12;
    localparam logic [4:0] OP_ADC   = 5'd13;
    localparam logic [4:0] OP_SUB   = 5'd14;
    localparam logic [4:0] OP_SBC   = 5'd15;
    localparam logic [4:0] OP_CMP   = 5'd16;
    localparam logic [4:0] OP_LDSR  = 5'd17;
    localparam logic [4:0] OP_XORSR = 5'd18;

    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_S = 2;

    // Clear the upper half when operating in half-word mode.
    function automatic logic [WIDTH-1:0] mask_w(input logic [WIDTH-1:0] v, input logic mode);
        return mode ? v : {{(WIDTH-HALF){1'b0}}, v[HALF-1:0]};
    endfunction

    function automatic logic sign_bit(input logic [WIDTH-1:0] v, input logic mode);
        return mode ? v[WIDTH-1] : v[HALF-1];
    endfunction

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    // Shift counts beyond the active width minus one are clamped.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] cnt, input logic mode);
        logic [CNT_W-1:0] lim;
        lim = mode ? CNT_W'(WIDTH-1) : CNT_W'(HALF-1);
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus between the issue stage, the ALU sequencer and the
// register-file writeback.
//   master : drives req_*, rsp_ready; observes req_ready, rsp_*, status
//   slave  : the sequencer side
interface alu_sequencer_if;
    import alu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic             req_mode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [CNT_W-1:0] req_cnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_c;
    logic [WIDTH-1:0] rsp_c2;
    logic             rsp_err;
    logic [2:0]       status;

    modport master (
        output req_valid, req_op, req_mode, req_a, req_b, req_cnt, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_c2, rsp_err, status
    );

    modport slave (
        input  req_valid, req_op, req_mode, req_a, req_b, req_cnt, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_c2, rsp_err, status
    );

endinterface

// File: rtl/alu_sequencer_core.sv
// alu_core: combinational wrapper over the logic, arithmetic, compare and
// single-bit shift circuits.
//   op, mode, a, b, status_in -> result, result2, status_next, err
//   step_in (with op, mode)   -> step_out, step_bit (one-bit shift/rotate)
// For shift/rotate ops the single-cycle result is the operand itself, which
// covers the zero-count case.
module alu_core
    import alu_pkg::*;
(
    input  logic [4:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       status_in,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic [2:0]       status_next,
    output logic             err,
    input  logic [WIDTH-1:0] step_in,
    output logic [WIDTH-1:0] step_out,
    output logic             step_bit
);

    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH:0]   arith;
    logic [WIDTH:0]   cin;
    logic             upd_sz;
    logic             upd_c;

    assign a_m = mask_w(a, mode);
    assign b_m = mask_w(b, mode);
    assign cin = (WIDTH+1)'(status_in[SR_C]);

    always_comb begin
        result      = '0;
        result2     = '0;
        status_next = status_in;
        err         = 1'b0;
        arith       = '0;
        upd_sz      = 1'b0;
        upd_c       = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_NOT:  begin result = mask_w(~a, mode); upd_sz = 1'b1; end
            OP_AND:  begin result = a_m & b_m;       upd_sz = 1'b1; end
            OP_OR:   begin result = a_m | b_m;       upd_sz = 1'b1; end
            OP_XOR:  begin result = a_m ^ b_m;       upd_sz = 1'b1; end
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                result = a_m;
                upd_sz = 1'b1;
            end
            OP_SWAP: begin result = b_m; result2 = a_m; end
            OP_INC:  begin arith = {1'b0, a_m} + (WIDTH+1)'(1);        upd_c = 1'b1; end
            OP_DEC:  begin arith = {1'b0, a_m} - (WIDTH+1)'(1);        upd_c = 1'b1; end
            OP_ADD:  begin arith = {1'b0, a_m} + {1'b0, b_m};          upd_c = 1'b1; end
            OP_ADC:  begin arith = {1'b0, a_m} + {1'b0, b_m} + cin;    upd_c = 1'b1; end
            OP_SUB:  begin arith = {1'b0, a_m} - {1'b0, b_m};          upd_c = 1'b1; end
            OP_SBC:  begin arith = {1'b0, a_m} - {1'b0, b_m} - cin;    upd_c = 1'b1; end
            OP_CMP: begin
                result            = a_m;
                status_next[SR_Z] = (a_m == b_m);
                status_next[SR_S] = mode ? ($signed(a) < $signed(b))
                                         : ($signed(a[HALF-1:0]) < $signed(b[HALF-1:0]));
            end
            OP_LDSR:  status_next = a[2:0];
            OP_XORSR: status_next = status_in ^ a[2:0];
            default:  err = 1'b1;
        endcase

        // Operands are pre-masked, so in half-word mode bit HALF of the
        // 21-bit sum/difference is the carry/borrow out of the low half.
        if (upd_c) begin
            result            = mask_w(arith[WIDTH-1:0], mode);
            status_next[SR_C] = mode ? arith[WIDTH] : arith[HALF];
            upd_sz            = 1'b1;
        end
        if (upd_sz) begin
            status_next[SR_Z] = (result == '0);
            status_next[SR_S] = sign_bit(result, mode);
        end
    end

    always_comb begin
        step_out = step_in;
        step_bit = 1'b0;
        case (op)
            OP_SHR: begin
                step_out = step_in >> 1;
                step_bit = step_in[0];
            end
            OP_SHL: begin
                step_out = mask_w(step_in << 1, mode);
                step_bit = sign_bit(step_in, mode);
            end
            OP_ROR: begin
                if (mode)
                    step_out = {step_in[0], step_in[WIDTH-1:1]};
                else
                    step_out = {{(WIDTH-HALF){1'b0}}, step_in[0], step_in[HALF-1:1]};
            end
            OP_ROL: begin
                if (mode)
                    step_out = {step_in[WIDTH-2:0], step_in[WIDTH-1]};
                else
                    step_out = {{(WIDTH-HALF){1'b0}}, step_in[HALF-2:0], step_in[HALF-1]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller for the 20-bit ALU. Accepts one
// operation per request handshake, iterates shifts/rotates one bit per
// cycle, owns the {sign, zero, carry} status register and returns results
// over the response handshake.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_sequencer_if.slave (req_*, rsp_*, status)
//
//   state   | meaning
//   IDLE    | req_ready high; accept edge registers single-cycle results
//   SHIFT   | one bit per cycle; last step registers result and flags
//   RESP    | rsp_valid high, outputs held until rsp_ready
module alu_sequencer
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_RESP
    } state_t;

    state_t           state;
    logic [4:0]       op_r;
    logic             mode_r;
    logic [WIDTH-1:0] sh_val;
    logic [CNT_W-1:0] count;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_c_r;
    logic [WIDTH-1:0] rsp_c2_r;
    logic             rsp_err_r;
    logic [2:0]       status_r;

    logic [4:0]       core_op;
    logic             core_mode;
    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] core_result2;
    logic [2:0]       core_status;
    logic             core_err;
    logic [WIDTH-1:0] step_out;
    logic             step_bit;
    logic [CNT_W-1:0] req_eff_cnt;

    // In IDLE the core evaluates the incoming request; while shifting it
    // steps the latched operation.
    assign core_op     = (state == S_IDLE) ? bus.req_op   : op_r;
    assign core_mode   = (state == S_IDLE) ? bus.req_mode : mode_r;
    assign req_eff_cnt = eff_count(bus.req_cnt, bus.req_mode);

    alu_core u_core (
        .op          (core_op),
        .mode        (core_mode),
        .a           (bus.req_a),
        .b           (bus.req_b),
        .status_in   (status_r),
        .result      (core_result),
        .result2     (core_result2),
        .status_next (core_status),
        .err         (core_err),
        .step_in     (sh_val),
        .step_out    (step_out),
        .step_bit    (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_r        <= OP_NOP;
            mode_r      <= 1'b0;
            sh_val      <= '0;
            count       <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_c_r     <= '0;
            rsp_c2_r    <= '0;
            rsp_err_r   <= 1'b0;
            status_r    <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_r        <= bus.req_op;
                        mode_r      <= bus.req_mode;
                        req_ready_r <= 1'b0;
                        if (is_shift_op(bus.req_op) && (req_eff_cnt != '0)) begin
                            sh_val <= mask_w(bus.req_a, bus.req_mode);
                            count  <= req_eff_cnt;
                            state  <= S_SHIFT;
                        end else begin
                            rsp_c_r     <= core_result;
                            rsp_c2_r    <= core_result2;
                            rsp_err_r   <= core_err;
                            status_r    <= core_status;
                            rsp_valid_r <= 1'b1;
                            state       <= S_RESP;
                        end
                    end
                end
                S_SHIFT: begin
                    sh_val <= step_out;
                    count  <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        rsp_c_r          <= step_out;
                        rsp_c2_r         <= '0;
                        rsp_err_r        <= 1'b0;
                        status_r[SR_Z]   <= (step_out == '0);
                        status_r[SR_S]   <= sign_bit(step_out, mode_r);
                        // Rotates leave carry alone; shifts keep the last bit out.
                        if ((op_r == OP_SHR) || (op_r == OP_SHL))
                            status_r[SR_C] <= step_bit;
                        rsp_valid_r      <= 1'b1;
                        state            <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_c     = rsp_c_r;
    assign bus.rsp_c2    = rsp_c2_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.status    = status_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a response scoreboard.
module tb_alu_sequencer;
    import alu_pkg::*;

    typedef struct {
        int          id;
        logic [19:0] c;
        logic [19:0] c2;
        logic        err;
        logic [2:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response against the queue head and
    // pops on handshake, so held values are re-checked on each stall cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_c 0x%0h, expected no response", bus.rsp_c);
                end else begin
                    check($sformatf("v%0d rsp_c", exp_q[0].id),   bus.rsp_c,   exp_q[0].c);
                    check($sformatf("v%0d rsp_c2", exp_q[0].id),  bus.rsp_c2,  exp_q[0].c2);
                    check($sformatf("v%0d rsp_err", exp_q[0].id), bus.rsp_err, exp_q[0].err);
                    check($sformatf("v%0d status", exp_q[0].id),  bus.status,  exp_q[0].st);
                    if (bus.rsp_ready)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input int id, input logic [4:0] op, input logic mode,
                         input logic [19:0] a, input logic [19:0] b, input logic [4:0] cnt,
                         input logic [19:0] ec, input logic [19:0] ec2, input logic eerr,
                         input logic [2:0] est, input int elat, input bit now = 1'b0);
        exp_t e;
        int   guard;
        int   lat;
        bit   rr_high;
        guard   = 0;
        rr_high = 1'b0;
        if (!now) begin
            @(posedge clk); #1;
        end
        while (!bus.req_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("v%0d req_ready_before", id), bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_mode  = mode;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cnt   = cnt;
        @(posedge clk);
        e.id = id; e.c = ec; e.c2 = ec2; e.err = eerr; e.st = est;
        exp_q.push_back(e);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 64) begin
            if (bus.req_ready) rr_high = 1'b1;
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", id), lat, elat);
        check($sformatf("v%0d req_ready_busy", id), rr_high | bus.req_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_NOP;
        bus.req_mode  = 1'b1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cnt   = '0;
        bus.rsp_ready = 1'b1;

        #12;
        check("reset req_ready", bus.req_ready, 1);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp_c",     bus.rsp_c, 0);
        check("reset rsp_c2",    bus.rsp_c2, 0);
        check("reset rsp_err",   bus.rsp_err, 0);
        check("reset status",    bus.status, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        //     id  op         md  a          b          cnt  exp_c      exp_c2     err  status  lat
        issue(1,  OP_ADD,    1, 20'hFFFFF, 20'h00001, 5'd0,  20'h00000, 20'h0, 1'b0, 3'b011, 1);
        issue(2,  OP_ADD,    0, 20'h003FF, 20'h00001, 5'd0,  20'h00000, 20'h0, 1'b0, 3'b011, 1);
        issue(3,  OP_ADC,    0, 20'h00001, 20'h00001, 5'd0,  20'h00003, 20'h0, 1'b0, 3'b000, 1);
        issue(4,  OP_SHR,    1, 20'h00007, 20'h0,     5'd2,  20'h00001, 20'h0, 1'b0, 3'b001, 3);
        issue(5,  OP_SHR,    1, 20'h80000, 20'h0,     5'd25, 20'h00001, 20'h0, 1'b0, 3'b000, 20);
        issue(6,  OP_ROR,    0, 20'h3FF01, 20'h0,     5'd12, 20'h00203, 20'h0, 1'b0, 3'b100, 10);
        issue(7,  OP_SHL,    1, 20'hFFFFF, 20'h0,     5'd0,  20'hFFFFF, 20'h0, 1'b0, 3'b100, 1);
        issue(8,  OP_SUB,    1, 20'h00001, 20'h00002, 5'd0,  20'hFFFFF, 20'h0, 1'b0, 3'b101, 1);
        issue(9,  OP_SBC,    1, 20'h00005, 20'h00002, 5'd0,  20'h00002, 20'h0, 1'b0, 3'b000, 1);
        issue(10, OP_NOT,    0, 20'h003FF, 20'h0,     5'd0,  20'h00000, 20'h0, 1'b0, 3'b010, 1);

        // Backpressure: hold the SWAP response four cycles while a request
        // is waved at the sequencer, then expect the next op right after.
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        issue(11, OP_SWAP,   1, 20'h12345, 20'h0ABCD, 5'd0,  20'h0ABCD, 20'h12345, 1'b0, 3'b010, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b1;
            bus.req_op    = OP_NOT;
            bus.req_a     = 20'h00001;
            check("stall req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_handshake req_ready", bus.req_ready, 1);
        check("post_handshake rsp_valid", bus.rsp_valid, 0);
        issue(12, OP_INC,    1, 20'h00005, 20'h0,     5'd0,  20'h00006, 20'h0, 1'b0, 3'b000, 1, 1'b1);

        issue(13, OP_LDSR,   1, 20'h00005, 20'h0,     5'd0,  20'h00000, 20'h0, 1'b0, 3'b101, 1);
        issue(14, OP_XORSR,  1, 20'h00007, 20'h0,     5'd0,  20'h00000, 20'h0, 1'b0, 3'b010, 1);
        issue(15, OP_CMP,    1, 20'h80000, 20'h00001, 5'd0,  20'h80000, 20'h0, 1'b0, 3'b100, 1);
        issue(16, OP_DEC,    1, 20'h00000, 20'h0,     5'd0,  20'hFFFFF, 20'h0, 1'b0, 3'b101, 1);
        issue(17, 5'd25,     1, 20'h00007, 20'h0,     5'd0,  20'h00000, 20'h0, 1'b1, 3'b101, 1);

        // Reset in the middle of a 10-step SHL: no response, status cleared.
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SHL;
        bus.req_mode  = 1'b1;
        bus.req_a     = 20'h00001;
        bus.req_cnt   = 5'd10;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        check("shl busy req_ready", bus.req_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort rsp_valid", bus.rsp_valid, 0);
        check("abort status",    bus.status, 0);
        check("abort req_ready", bus.req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("after_abort rsp_valid", bus.rsp_valid, 0);
        end
        check("after_abort req_ready", bus.req_ready, 1);

        issue(18, OP_XOR,    1, 20'hF0F0F, 20'h0FFFF, 5'd0,  20'hFF0F0, 20'h0, 1'b0, 3'b100, 1);

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
